// File: rtl/aes_pkg.sv
// Shared AES definitions: round count, key index width, controller state encoding
// and the GF(2^8) helpers used by the decrypt datapath and the future encrypt controller.
package aes_pkg;

  localparam int AES_NR     = 10;
  localparam int AES_KIDX_W = 4;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_INIT,
    ST_ROUND,
    ST_FINAL,
    ST_DONE
  } ctrl_state_e;

  function automatic logic [7:0] gf_xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] acc;
    logic [7:0] p;
    acc = '0;
    p   = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) acc = acc ^ p;
      p = gf_xtime(p);
    end
    return acc;
  endfunction

  // Inverse affine transform followed by field inversion, computed as x^254.
  function automatic logic [7:0] inv_sbox(input logic [7:0] x);
    logic [7:0] a;
    logic [7:0] p;
    logic [7:0] r;
    for (int i = 0; i < 8; i++) begin
      a[i] = x[(i + 2) % 8] ^ x[(i + 5) % 8] ^ x[(i + 7) % 8];
    end
    a = a ^ 8'h05;
    p = a;
    r = 8'h01;
    for (int i = 1; i < 8; i++) begin
      p = gf_mul(p, p);
      r = gf_mul(r, p);
    end
    return r;
  endfunction

endpackage

// File: rtl/inv_round.sv
// One middle round of the inverse cipher, ordered so the controller can chain it:
// AddRoundKey, InvMixColumns, then InvShiftRows and InvSubBytes of the following round.
module inv_round
  import aes_pkg::*;
(
  input  logic [127:0] state_i,
  input  logic [127:0] key_i,
  output logic [127:0] state_o
);

  logic [127:0] mixed;
  logic [127:0] shifted;

  function automatic logic [31:0] inv_mix_col(input logic [31:0] col);
    logic [7:0] a0, a1, a2, a3;
    {a0, a1, a2, a3} = col;
    return {gf_mul(a0, 8'h0e) ^ gf_mul(a1, 8'h0b) ^ gf_mul(a2, 8'h0d) ^ gf_mul(a3, 8'h09),
            gf_mul(a0, 8'h09) ^ gf_mul(a1, 8'h0e) ^ gf_mul(a2, 8'h0b) ^ gf_mul(a3, 8'h0d),
            gf_mul(a0, 8'h0d) ^ gf_mul(a1, 8'h09) ^ gf_mul(a2, 8'h0e) ^ gf_mul(a3, 8'h0b),
            gf_mul(a0, 8'h0b) ^ gf_mul(a1, 8'h0d) ^ gf_mul(a2, 8'h09) ^ gf_mul(a3, 8'h0e)};
  endfunction

  always_comb begin
    mixed = '0;
    for (int c = 0; c < 4; c++) begin
      mixed[127 - 32 * c -: 32] = inv_mix_col(state_i[127 - 32 * c -: 32] ^ key_i[127 - 32 * c -: 32]);
    end
  end

  inv_shift_rows u_shift (
    .data_i(mixed),
    .data_o(shifted)
  );

  inv_sub_bytes u_sub (
    .data_i(shifted),
    .data_o(state_o)
  );

endmodule

// File: rtl/inv_shift_rows.sv
// AES InvShiftRows: row r of the column-major state rotates right by r bytes.
module inv_shift_rows (
  input  logic [127:0] data_i,
  output logic [127:0] data_o
);

  always_comb begin
    data_o = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        data_o[127 - 8 * (4 * c + r) -: 8] = data_i[127 - 8 * (4 * ((c + 4 - r) % 4) + r) -: 8];
      end
    end
  end

endmodule

// File: rtl/inv_sub_bytes.sv
// AES InvSubBytes: the inverse S-box applied to all sixteen state bytes.
module inv_sub_bytes
  import aes_pkg::*;
(
  input  logic [127:0] data_i,
  output logic [127:0] data_o
);

  always_comb begin
    data_o = '0;
    for (int i = 0; i < 16; i++) begin
      data_o[8 * i +: 8] = inv_sbox(data_i[8 * i +: 8]);
    end
  end

endmodule

// File: rtl/inv_cipher_ctrl.sv
// Iterative AES-128 decrypt controller: one round per clock, round keys fetched
// from an external store through key_idx/round_key, valid/ready on both sides.
module inv_cipher_ctrl
  import aes_pkg::*;
#(
  parameter int NR     = AES_NR,
  parameter int KIDX_W = AES_KIDX_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [127:0]      in_data,
  output logic [KIDX_W-1:0] key_idx,
  input  logic [127:0]      round_key,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [127:0]      out_data,
  output logic              busy
);

  ctrl_state_e       state_q, state_d;
  logic [KIDX_W-1:0] rnd_q, rnd_d;
  logic [127:0]      blk_q, blk_d;
  logic [127:0]      out_q, out_d;
  logic [127:0]      init_shifted;
  logic [127:0]      init_res;
  logic [127:0]      round_res;

  // The first step has no InvMixColumns, so it uses the bare shift/sub leaves.
  inv_shift_rows u_init_shift (
    .data_i(blk_q ^ round_key),
    .data_o(init_shifted)
  );

  inv_sub_bytes u_init_sub (
    .data_i(init_shifted),
    .data_o(init_res)
  );

  inv_round u_round (
    .state_i(blk_q),
    .key_i  (round_key),
    .state_o(round_res)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      rnd_q   <= '0;
      blk_q   <= '0;
      out_q   <= '0;
    end else begin
      state_q <= state_d;
      rnd_q   <= rnd_d;
      blk_q   <= blk_d;
      out_q   <= out_d;
    end
  end

  // key_idx rests at NR outside the rounds so the first key is already prefetched.
  always_comb begin
    state_d = state_q;
    rnd_d   = rnd_q;
    blk_d   = blk_q;
    out_d   = out_q;
    key_idx = KIDX_W'(NR);
    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          blk_d   = in_data;
          rnd_d   = KIDX_W'(NR - 1);
          state_d = ST_INIT;
        end
      end
      ST_INIT: begin
        blk_d   = init_res;
        state_d = ST_ROUND;
      end
      ST_ROUND: begin
        key_idx = rnd_q;
        blk_d   = round_res;
        rnd_d   = rnd_q - KIDX_W'(1);
        if (rnd_q == KIDX_W'(1)) state_d = ST_FINAL;
      end
      ST_FINAL: begin
        key_idx = '0;
        out_d   = blk_q ^ round_key;
        state_d = ST_DONE;
      end
      ST_DONE: begin
        if (out_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign in_ready  = (state_q == ST_IDLE);
  assign out_valid = (state_q == ST_DONE);
  assign busy      = (state_q != ST_IDLE);
  assign out_data  = out_q;

endmodule

// File: tb/tb_inv_cipher_ctrl.sv
// Directed bench for inv_cipher_ctrl: FIPS-197 C.1, key sequencing, backpressure,
// back-to-back blocks, mid-block reset and an all-zero vector against a table-driven model.
module tb_inv_cipher_ctrl;

  localparam logic [127:0] C1_KEY = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] C1_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] C1_PT  = 128'h00112233445566778899aabbccddeeff;

  logic         clk;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] in_data;
  logic [3:0]   key_idx;
  logic [127:0] round_key;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] out_data;
  logic         busy;

  int total = 0;
  int bad   = 0;

  logic [7:0]   sb  [0:255];
  logic [7:0]   isb [0:255];
  logic [127:0] rk  [0:10];

  logic monOn = 1'b0;
  int   keySeq[$];

  inv_cipher_ctrl #(.NR(10), .KIDX_W(4)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .key_idx  (key_idx),
    .round_key(round_key),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .busy     (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // External key store: answers key_idx combinationally.
  always_comb begin
    round_key = '0;
    if (key_idx <= 4'd10) round_key = rk[key_idx];
  end

  always @(negedge clk) begin
    if (monOn && busy && !out_valid) keySeq.push_back(int'(key_idx));
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gm(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] acc;
    logic [7:0] p;
    acc = '0;
    p   = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) acc = acc ^ p;
      p = xt(p);
    end
    return acc;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
    logic [15:0] d;
    d = {b, b};
    return d[15 - n -: 8];
  endfunction

  // Forward S-box by brute-force inverse search plus affine map; the decrypt table is its inverse.
  task automatic buildTables();
    logic [7:0] inv;
    logic [7:0] s;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int c = 1; c < 256; c++) begin
        if (x != 0 && gm(8'(x), 8'(c)) == 8'h01) inv = 8'(c);
      end
      s = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
      sb[x]  = s;
      isb[s] = 8'(x);
    end
  endtask

  task automatic expandKey(input logic [127:0] key);
    logic [31:0] w [0:43];
    logic [31:0] t;
    logic [7:0]  rcon;
    rcon = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = key[127 - 32 * i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i - 1];
      if (i % 4 == 0) begin
        t = {sb[t[23:16]], sb[t[15:8]], sb[t[7:0]], sb[t[31:24]]} ^ {rcon, 24'h0};
        rcon = xt(rcon);
      end
      w[i] = w[i - 4] ^ t;
    end
    for (int r = 0; r < 11; r++) rk[r] = {w[4 * r], w[4 * r + 1], w[4 * r + 2], w[4 * r + 3]};
  endtask

  function automatic logic [127:0] mShiftSub(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        o[127 - 8 * (4 * c + r) -: 8] = isb[s[127 - 8 * (4 * ((c + 4 - r) % 4) + r) -: 8]];
    return o;
  endfunction

  function automatic logic [127:0] mInvMix(input logic [127:0] s);
    logic [7:0]   coef [0:3];
    logic [127:0] o;
    logic [7:0]   acc;
    coef = '{8'h0e, 8'h0b, 8'h0d, 8'h09};
    o = '0;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++) begin
        acc = 8'h00;
        for (int j = 0; j < 4; j++) acc = acc ^ gm(coef[(j + 4 - r) % 4], s[127 - 8 * (4 * c + j) -: 8]);
        o[127 - 8 * (4 * c + r) -: 8] = acc;
      end
    return o;
  endfunction

  function automatic logic [127:0] modelDecrypt(input logic [127:0] ct);
    logic [127:0] s;
    s = ct ^ rk[10];
    for (int r = 9; r >= 1; r--) s = mInvMix(mShiftSub(s) ^ rk[r]);
    return mShiftSub(s) ^ rk[0];
  endfunction

  task automatic checkOutput(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Offers one block, checks it is taken, and counts edges until out_valid.
  task automatic applyStimulus(input logic [127:0] ct, output int lat);
    in_data  = ct;
    in_valid = 1'b1;
    checkOutput("accept_ready", 128'(in_ready), 128'(1));
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 30) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  initial begin
    int           lat;
    int           seen;
    logic [127:0] bbCt [0:2];
    logic [127:0] bbPt [0:2];
    logic [127:0] zPt;

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;
    buildTables();
    expandKey(C1_KEY);

    @(posedge clk); #1;
    checkOutput("rst_out_valid", 128'(out_valid), 128'(0));
    checkOutput("rst_busy", 128'(busy), 128'(0));
    checkOutput("rst_out_data", out_data, 128'(0));
    checkOutput("rst_key_idx", 128'(key_idx), 128'(10));
    rst_n = 1'b1;
    @(posedge clk); #1;
    checkOutput("rst_in_ready", 128'(in_ready), 128'(1));

    $display("[TB] FIPS-197 C.1 with key sequencing and backpressure");
    keySeq.delete();
    monOn = 1'b1;
    applyStimulus(C1_CT, lat);
    monOn = 1'b0;
    checkOutput("c1_latency", 128'(lat), 128'(11));
    checkOutput("c1_data", out_data, C1_PT);
    checkOutput("keyseq_len", 128'(keySeq.size()), 128'(11));
    for (int i = 0; i < 11; i++) begin
      if (i < keySeq.size()) checkOutput($sformatf("keyseq_%0d", i), 128'(keySeq[i]), 128'(10 - i));
    end
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1;
      in_data  = {$urandom, $urandom, $urandom, $urandom};
      @(posedge clk); #1;
      checkOutput("bp_valid", 128'(out_valid), 128'(1));
      checkOutput("bp_data", out_data, C1_PT);
      checkOutput("bp_in_ready", 128'(in_ready), 128'(0));
      checkOutput("bp_key_idx", 128'(key_idx), 128'(10));
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    checkOutput("hs_valid_low", 128'(out_valid), 128'(0));
    checkOutput("hs_in_ready", 128'(in_ready), 128'(1));
    @(posedge clk); #1;
    checkOutput("hs_stays_idle", 128'(busy), 128'(0));

    $display("[TB] back-to-back blocks");
    bbCt[0] = C1_CT;
    bbCt[1] = 128'h00000000000000000000000000000000;
    bbCt[2] = 128'hdeadbeef0123456789abcdeffedcba98;
    bbPt[0] = C1_PT;
    bbPt[1] = modelDecrypt(bbCt[1]);
    bbPt[2] = modelDecrypt(bbCt[2]);
    in_valid  = 1'b1;
    out_ready = 1'b1;
    in_data   = bbCt[0];
    @(posedge clk); #1;
    for (int b = 0; b < 3; b++) begin
      if (b < 2) in_data = bbCt[b + 1];
      lat = 0;
      while (!out_valid && lat < 30) begin
        @(posedge clk); #1;
        lat++;
      end
      checkOutput($sformatf("b2b_latency_%0d", b), 128'(lat), 128'(11));
      checkOutput($sformatf("b2b_data_%0d", b), out_data, bbPt[b]);
      @(posedge clk); #1;
      checkOutput($sformatf("b2b_in_ready_%0d", b), 128'(in_ready), 128'(1));
      if (b == 2) in_valid = 1'b0;
      @(posedge clk); #1;
      checkOutput($sformatf("b2b_accept_%0d", b), 128'(busy), 128'(b < 2));
    end
    out_ready = 1'b0;

    $display("[TB] reset in the middle of a block");
    in_data  = C1_CT;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    checkOutput("mid_key_idx", 128'(key_idx), 128'(5));
    rst_n = 1'b0;
    #1;
    checkOutput("mid_rst_valid", 128'(out_valid), 128'(0));
    checkOutput("mid_rst_busy", 128'(busy), 128'(0));
    checkOutput("mid_rst_data", out_data, 128'(0));
    checkOutput("mid_rst_key_idx", 128'(key_idx), 128'(10));
    @(posedge clk); #1;
    rst_n = 1'b1;
    seen = 0;
    repeat (15) begin
      @(posedge clk); #1;
      if (out_valid) seen++;
    end
    checkOutput("mid_no_stale", 128'(seen), 128'(0));
    applyStimulus(C1_CT, lat);
    checkOutput("post_rst_latency", 128'(lat), 128'(11));
    checkOutput("post_rst_data", out_data, C1_PT);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;

    $display("[TB] all-zero key and ciphertext");
    expandKey(128'h0);
    zPt = modelDecrypt(128'h0);
    @(posedge clk); #1;
    applyStimulus(128'h0, lat);
    checkOutput("zero_latency", 128'(lat), 128'(11));
    checkOutput("zero_data", out_data, zPt);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    checkOutput("zero_done", 128'(busy), 128'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/inv_cipher_ctrl.md
INV_CIPHER_CTRL -- requirements
Module: inv_cipher_ctrl

Interface
REQ-001 SHALL have parameter NR, default 10, number of AES rounds; only 10 (AES-128) is supported.
REQ-002 SHALL have parameter KIDX_W, default 4, width of the round-key index.
REQ-003 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port in_valid, input, 1, ciphertext block offered.
REQ-006 SHALL have port in_ready, output, 1, block accepted when in_valid&in_ready at a rising edge.
REQ-007 SHALL have port in_data, input, 128, ciphertext block.
REQ-008 SHALL have port key_idx, output, KIDX_W, index of the round key required this cycle.
REQ-009 SHALL have port round_key, input, 128, key for key_idx, valid combinationally in the same cycle.
REQ-010 SHALL have port out_valid, output, 1, plaintext available.
REQ-011 SHALL have port out_ready, input, 1, plaintext consumed when out_valid&out_ready at a rising edge.
REQ-012 SHALL have port out_data, output, 128, plaintext block.
REQ-013 SHALL have port busy, output, 1, high in every state except IDLE.

Function
REQ-014 SHALL implement FSM states IDLE, INIT, ROUND, FINAL, DONE.
REQ-015 SHALL hold a 128-bit state register and a KIDX_W-bit round counter rnd.
REQ-016 SHALL assert in_ready only in IDLE; on accept: state<=in_data, rnd<=NR-1, go INIT.
REQ-017 INIT: key_idx=NR; state<=InvSubBytes(InvShiftRows(state^round_key)); go ROUND.
REQ-018 ROUND: key_idx=rnd; state<=inv_round(state, round_key); rnd<=rnd-1; go FINAL when rnd==1, else stay.
REQ-019 FINAL: key_idx=0; out_data<=state^round_key; go DONE.
REQ-020 DONE: out_valid=1; out_data held stable until handshake; on out_ready go IDLE.
REQ-021 key_idx SHALL equal NR in IDLE and DONE (prefetch for the next block).
REQ-022 Latency: out_valid SHALL rise exactly 11 rising edges after the accepting edge (1 INIT + 9 ROUND + 1 FINAL); next accept no earlier than 1 edge after the output handshake.
REQ-023 in_valid SHALL be ignored outside IDLE; out_ready SHALL be ignored outside DONE.
REQ-024 out_valid SHALL stay high through any number of out_ready-low cycles (backpressure), with no state change.
REQ-025 round_key SHALL be sampled only in INIT, ROUND and FINAL; its value in other states has no effect.
REQ-026 rnd SHALL never wrap: ROUND is entered with rnd=9 and left with rnd=1.

Reset
REQ-027 rst_n low SHALL immediately force IDLE, rnd=0, state=0, out_data=0, out_valid=0, busy=0, in_ready=1 after release, key_idx=NR.
REQ-028 Reset asserted mid-block SHALL discard the block; no out_valid for it after release.

Structure
REQ-029 State encoding, NR and KIDX_W SHALL live in shared package aes_pkg, reused by the future encrypt controller.
REQ-030 SHALL instantiate exactly one inv_round for REQ-018; INIT SHALL reuse the existing inv_shift_rows and inv_sub_bytes leaf modules; no other sub-modules.
REQ-031 Key storage/expansion SHALL stay outside this block.

Verification
REQ-032 FIPS-197 C.1: key 000102..0f expanded by the bench model, in_data 69c4e0d86a7b0430d8cdb78070b4c55a -> out_data 00112233445566778899aabbccddeeff, out_valid exactly 11 edges after accept.
REQ-033 Key sequencing: monitor key_idx in the sampling states -> 10,9,8,...,1,0 exactly, one value per cycle.
REQ-034 Backpressure: out_ready low 5 cycles after out_valid -> out_data/out_valid stable, in_ready=0, in_valid pulses ignored.
REQ-035 Back-to-back: in_valid held high, out_ready high, 3 blocks -> 3 correct plaintexts, each accepted 1 edge after the previous output handshake.
REQ-036 Reset at ROUND rnd=5 -> outputs 0, IDLE, no stale out_valid; next C.1 block decrypts correctly.
REQ-037 Zero vectors: ciphertext and key all-zero through the bench model -> out_data matches the model value.
